display_scan_ctrl: RTL and testbench

Time-multiplexing scan controller that shares one 3-bit seven-segment decoder across NUM_DIGITS digit positions. It holds a shadow and an active bank of per-digit codes and blank flags. Each digit is selected in turn for a fixed slot, with a blanking guard interval between digits to suppress ghosting. Shadow-to-active commits happen only at frame boundaries, so the displayed frame never tears. The block sits between the host-side register writer and the decoder/anode drivers.

---
 rtl/display_scan_ctrl.sv | 166 ++++++++++++++++
 tb/tb_display_scan_ctrl.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl
// Time-multiplexed scan controller sharing one 3-bit segment decoder across
// NUM_DIGITS digit positions. The host writes a shadow bank of {blank, code}
// entries. A commit copies shadow to active only at a frame boundary (or at
// once while the display is off), so the displayed frame never tears. Each
// digit slot is DIV cycles long: GUARD blanked cycles, then the rest driven.
//
// Ports:
//   clk, reset         single clock, synchronous active-high reset
//   enable             1 = scanning, 0 = display off
//   wr_en/wr_addr/     shadow bank write; wr_addr >= NUM_DIGITS is ignored
//   wr_data/wr_blank
//   commit / busy      request a shadow->active copy / copy pending
//   commit_done        one-cycle pulse when the copy happens
//   frame_done         one-cycle pulse on the wrap from last digit to digit 0
//   dec_code           code presented to the decoder (MSB = A)
//   dig_en             one-hot active-high digit enable
module display_scan_ctrl #(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned DIV        = 50000,
  parameter int unsigned GUARD      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  wr_en,
  input  logic [2:0]            wr_addr,
  input  logic [2:0]            wr_data,
  input  logic                  wr_blank,
  input  logic                  commit,
  output logic                  busy,
  output logic                  commit_done,
  output logic                  frame_done,
  output logic [2:0]            dec_code,
  output logic [NUM_DIGITS-1:0] dig_en
);

  localparam int unsigned CntW = $clog2(DIV);
  localparam int unsigned IdxW = ($clog2(NUM_DIGITS) > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CntW-1:0] CntLast   = CntW'(DIV - 1);
  localparam logic [CntW-1:0] GuardLast = CntW'(GUARD - 1);
  localparam logic [IdxW-1:0] IdxLast   = IdxW'(NUM_DIGITS - 1);

  // Each entry is {blank, code}; reset value is blank with code 0.
  localparam logic [NUM_DIGITS-1:0][3:0] BankReset = {NUM_DIGITS{4'b1000}};
  localparam logic [NUM_DIGITS-1:0]      OneHot0   = {{(NUM_DIGITS-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {StOff, StGuard, StDrive} state_e;

  state_e                      state_q, state_d;
  logic [CntW-1:0]             cnt_q, cnt_d;
  logic [IdxW-1:0]             idx_q, idx_d;
  logic [NUM_DIGITS-1:0][3:0]  shadow_q, shadow_d;
  logic [NUM_DIGITS-1:0][3:0]  active_q, active_d;
  logic                        busy_q, busy_d;
  logic                        commit_done_q, commit_done_d;
  logic                        frame_done_q, frame_done_d;
  logic [2:0]                  dec_code_q, dec_code_d;
  logic [NUM_DIGITS-1:0]       dig_en_q, dig_en_d;
  logic                        wrap;
  logic                        copy;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    active_d = active_q;
    busy_d   = busy_q;
    wrap     = 1'b0;

    case (state_q)
      StOff: begin
        if (enable) begin
          state_d = StGuard;
          cnt_d   = '0;
          idx_d   = '0;
        end
      end
      StGuard: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == GuardLast) state_d = StDrive;
      end
      StDrive: begin
        if (cnt_q == CntLast) begin
          state_d = StGuard;
          cnt_d   = '0;
          if (idx_q == IdxLast) begin
            idx_d = '0;
            wrap  = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StOff;
    endcase

    // Dropping enable wins over everything, mid-slot included.
    if (!enable) begin
      state_d = StOff;
      cnt_d   = '0;
      idx_d   = '0;
      wrap    = 1'b0;
    end

    // Only a commit already pending before this edge may copy; a commit
    // arriving in the wrap cycle waits for the next frame boundary.
    copy = busy_q && (wrap || (state_q == StOff));
    if (copy) begin
      active_d = shadow_q;
      busy_d   = 1'b0;
    end else if (commit) begin
      busy_d = 1'b1;
    end

    if (wr_en && ({29'd0, wr_addr} < NUM_DIGITS)) begin
      shadow_d[wr_addr[IdxW-1:0]] = {wr_blank, wr_data};
    end

    // Outputs are registered from next-state values so they line up with
    // the state they describe, including a freshly committed digit 0.
    dec_code_d = '0;
    dig_en_d   = '0;
    if (state_d != StOff) dec_code_d = active_d[idx_d][2:0];
    if (state_d == StDrive && !active_d[idx_d][3]) dig_en_d = OneHot0 << idx_d;
    frame_done_d  = wrap;
    commit_done_d = copy;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StOff;
      cnt_q         <= '0;
      idx_q         <= '0;
      shadow_q      <= BankReset;
      active_q      <= BankReset;
      busy_q        <= 1'b0;
      commit_done_q <= 1'b0;
      frame_done_q  <= 1'b0;
      dec_code_q    <= '0;
      dig_en_q      <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      shadow_q      <= shadow_d;
      active_q      <= active_d;
      busy_q        <= busy_d;
      commit_done_q <= commit_done_d;
      frame_done_q  <= frame_done_d;
      dec_code_q    <= dec_code_d;
      dig_en_q      <= dig_en_d;
    end
  end

  assign busy        = busy_q;
  assign commit_done = commit_done_q;
  assign frame_done  = frame_done_q;
  assign dec_code    = dec_code_q;
  assign dig_en      = dig_en_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
module tb_display_scan_ctrl;

  localparam int N     = 4;
  localparam int DIVP  = 8;
  localparam int GRD   = 2;
  localparam int FRAME = N * DIVP;
  localparam int VW    = N + 6;

  logic         clk = 1'b0;
  logic         reset, enable, wr_en, wr_blank, commit;
  logic [2:0]   wr_addr, wr_data;
  logic         busy, commit_done, frame_done;
  logic [2:0]   dec_code;
  logic [N-1:0] dig_en;

  display_scan_ctrl #(.NUM_DIGITS(N), .DIV(DIVP), .GUARD(GRD)) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_blank    (wr_blank),
    .commit      (commit),
    .busy        (busy),
    .commit_done (commit_done),
    .frame_done  (frame_done),
    .dec_code    (dec_code),
    .dig_en      (dig_en)
  );

  always #5 clk = ~clk;

  // Reference model: scan position is simply the number of cycles since
  // scanning began, modulo the frame length.
  bit         m_run;
  int         m_t;
  logic [3:0] m_sh [N];
  logic [3:0] m_ac [N];
  bit         m_busy;
  logic [N-1:0] e_dig;
  logic [2:0] e_code;
  bit         e_cd, e_fd;

  int checks = 0;
  int errors = 0;

  function automatic logic [VW-1:0] obs_vec();
    return {dig_en, dec_code, busy, commit_done, frame_done};
  endfunction

  function automatic logic [VW-1:0] exp_vec();
    return {e_dig, e_code, m_busy, e_cd, e_fd};
  endfunction

  // Advance the model with the inputs currently driven, then clock the DUT.
  task automatic tick();
    bit wrap, copy;
    int d;
    if (reset) begin
      m_run = 0; m_t = 0; m_busy = 0;
      for (int i = 0; i < N; i++) begin m_sh[i] = 4'b1000; m_ac[i] = 4'b1000; end
      e_dig = '0; e_code = '0; e_cd = 0; e_fd = 0;
    end else begin
      wrap = m_run && enable && (m_t == FRAME - 1);
      copy = m_busy && (wrap || !m_run);
      if (copy) begin
        for (int i = 0; i < N; i++) m_ac[i] = m_sh[i];
        m_busy = 0;
      end else if (commit) begin
        m_busy = 1;
      end
      if (wr_en && wr_addr < N) m_sh[wr_addr] = {wr_blank, wr_data};
      if (!enable) begin m_run = 0; m_t = 0; end
      else if (!m_run) begin m_run = 1; m_t = 0; end
      else m_t = (m_t + 1) % FRAME;
      e_dig = '0; e_code = '0;
      if (m_run) begin
        d = m_t / DIVP;
        e_code = m_ac[d][2:0];
        if ((m_t % DIVP) >= GRD && !m_ac[d][3]) e_dig = N'(1) << d;
      end
      e_cd = copy; e_fd = wrap;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1; enable = 1; wr_en = 0; wr_addr = 0; wr_data = 0; wr_blank = 0; commit = 0;
    tick(); tick();
    checks++;
    if (obs_vec() !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %b want %b", obs_vec(), {VW{1'b0}});
    end
    reset = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      checks++;
      if (dig_en !== '0 || obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL reset_all_blank cyc %0d: got %b want %b", k, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_write_commit_scan();
    logic [2:0] codes [N];
    logic [N-1:0] want_dig;
    bit seen;
    codes[0] = 3'd5; codes[1] = 3'd3; codes[2] = 3'd7; codes[3] = 3'd1;
    for (int i = 0; i < N; i++) begin
      wr_en = 1; wr_addr = 3'(i); wr_data = codes[i]; wr_blank = 0;
      tick();
    end
    wr_en = 0; commit = 1;
    tick();
    commit = 0;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL commit_sets_busy: got %b want 1", busy); end
    seen = 0;
    for (int k = 0; k < 2 * FRAME && !seen; k++) begin
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL wcs_wait: got %b want %b", obs_vec(), exp_vec());
      end
      if (commit_done) seen = 1; else tick();
    end
    checks++;
    if (!seen || frame_done !== 1'b1 || dec_code !== 3'd5) begin
      errors++;
      $display("FAIL commit_with_frame: seen %0d fd %b code %0d want 1 1 5", seen, frame_done,
               dec_code);
    end
    for (int k = 1; k <= FRAME; k++) begin
      tick();
      want_dig = ((k % FRAME) % DIVP >= GRD) ? N'(1) << ((k % FRAME) / DIVP) : '0;
      checks++;
      if (dig_en !== want_dig || dec_code !== codes[(k % FRAME) / DIVP] ||
          frame_done !== (k == FRAME) || obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL scan_pattern k %0d: dig %b code %0d fd %b want %b %0d %b", k, dig_en,
                 dec_code, frame_done, want_dig, codes[(k % FRAME) / DIVP], k == FRAME);
      end
    end
  endtask

  task automatic test_tear_free();
    bit seen;
    while (m_t != 4) tick();
    wr_en = 1; wr_addr = 3'd2; wr_data = 3'd4; wr_blank = 0;
    tick();
    wr_en = 0;
    for (int k = 0; k < FRAME; k++) begin
      tick();
      checks++;
      if ((dig_en == 4'b0100 && dec_code !== 3'd7) || obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL no_tear: got %b want %b (digit2 code 7)", obs_vec(), exp_vec());
      end
    end
    commit = 1;
    tick();
    commit = 0;
    seen = 0;
    for (int k = 0; k < 2 * FRAME && !seen; k++) begin
      checks++;
      if (busy !== 1'b1 || obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL busy_held: got %b want %b", obs_vec(), exp_vec());
      end
      tick();
      if (commit_done) seen = 1;
    end
    checks++;
    if (!seen || busy !== 1'b0) begin
      errors++; $display("FAIL midframe_commit: seen %0d busy %b want 1 0", seen, busy);
    end
    for (int k = 0; k < FRAME; k++) begin
      tick();
      checks++;
      if ((dig_en == 4'b0100 && dec_code !== 3'd4) || obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL new_frame: got %b want %b (digit2 code 4)", obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_commit_at_wrap();
    int gap;
    wr_en = 1; wr_addr = 3'd0; wr_data = 3'd2; wr_blank = 0;
    tick();
    wr_en = 0;
    while (m_t != FRAME - 1) tick();
    commit = 1;
    tick();
    commit = 0;
    checks++;
    if (frame_done !== 1'b1 || commit_done !== 1'b0 || busy !== 1'b1 || dec_code !== 3'd5) begin
      errors++;
      $display("FAIL wrap_cycle_commit: fd %b cd %b busy %b code %0d want 1 0 1 5", frame_done,
               commit_done, busy, dec_code);
    end
    gap = 1;
    while (m_t != FRAME - 1) begin tick(); gap++; end
    wr_en = 1; wr_addr = 3'd0; wr_data = 3'd6; wr_blank = 0;
    tick();
    wr_en = 0;
    checks++;
    if (commit_done !== 1'b1 || frame_done !== 1'b1 || dec_code !== 3'd2 || gap != FRAME ||
        obs_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL delayed_copy: cd %b fd %b code %0d gap %0d want 1 1 2 %0d", commit_done,
               frame_done, dec_code, gap, FRAME);
    end
  endtask

  task automatic test_enable_drop();
    while (m_t != DIVP + 4) tick();
    enable = 0;
    tick();
    checks++;
    if (dig_en !== '0 || dec_code !== 3'd0 || obs_vec() !== exp_vec()) begin
      errors++; $display("FAIL enable_drop: dig %b code %0d want 0 0", dig_en, dec_code);
    end
    tick(); tick();
    enable = 1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (dig_en !== ((k == 2) ? 4'b0001 : 4'b0000) || dec_code !== 3'd2 ||
          obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL reenable k %0d: dig %b code %0d want %b 2", k, dig_en, dec_code,
                 (k == 2) ? 4'b0001 : 4'b0000);
      end
    end
  endtask

  task automatic test_blank_addr();
    logic [2:0] codes [N];
    bit seen;
    codes[0] = 3'd6; codes[1] = 3'd3; codes[2] = 3'd4; codes[3] = 3'd1;
    wr_en = 1; wr_addr = 3'd3; wr_data = 3'd1; wr_blank = 1;
    tick();
    wr_addr = 3'd5; wr_data = 3'd7; wr_blank = 0;
    tick();
    wr_en = 0; commit = 1;
    tick();
    commit = 0;
    seen = 0;
    for (int k = 0; k < 2 * FRAME && !seen; k++) begin
      tick();
      if (commit_done) seen = 1;
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL blank_commit_timeout: seen 0 want 1"); end
    for (int k = 0; k < FRAME; k++) begin
      checks++;
      if (dig_en[3] !== 1'b0 || dec_code !== codes[m_t / DIVP] || obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL blank_addr t %0d: dig %b code %0d want dig3=0 code %0d", m_t, dig_en,
                 dec_code, codes[m_t / DIVP]);
      end
      tick();
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 1500; k++) begin
      reset    = ($urandom_range(0, 299) == 0);
      enable   = ($urandom_range(0, 59) != 0);
      wr_en    = ($urandom_range(0, 3) == 0);
      wr_addr  = 3'($urandom_range(0, 7));
      wr_data  = 3'($urandom_range(0, 7));
      wr_blank = ($urandom_range(0, 3) == 0);
      commit   = ($urandom_range(0, 19) == 0);
      tick();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL random cyc %0d: got %b want %b", k, obs_vec(), exp_vec());
      end
    end
    reset = 0; enable = 1; wr_en = 0; commit = 0;
  endtask

  initial begin
    test_reset();
    test_write_commit_scan();
    test_tear_free();
    test_commit_at_wrap();
    test_enable_drop();
    test_blank_addr();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
